rx_frame_arbiter: RTL
=====================

RX_FRAME_ARBITER -- requirements
Module: rx_frame_arbiter

Interface
REQ-001 Parameter NRX, default 4, meaning number of receiver channels, legal range 1..8.
REQ-002 Parameter DW, default 24, meaning I/Q sample width per component.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- clock  input  1  -- sole clock, 61.44 MHz.
- rst_n  input  1  -- asynchronous active-low reset.
- enable_mask  input  NRX  -- channels taking part in a frame.
- in_strobe  input  NRX  -- one-cycle sample-valid, one bit per receiver.
- in_I  input  NRX*DW  -- packed I samples; channel k occupies bits [k*DW +: DW].
- in_Q  input  NRX*DW  -- packed Q samples; same packing as in_I.
- out_valid  output  1  -- output sample valid.
- out_ready  input  1  -- downstream accept.
- out_I  output  DW  -- I sample.
- out_Q  output  DW  -- Q sample.
- out_chan  output  3  -- source channel index.
- out_last  output  1  -- last sample of the frame.
- overflow  output  NRX  -- sticky per-channel drop flag.
- clr_overflow  input  1  -- clears all overflow bits.

Function
REQ-004 Each channel SHALL have a holding slot with I, Q and a full flag.
- in_strobe[k] with the slot empty loads in_I/in_Q into the slot.
- The full flag is set on the next clock edge.
REQ-005 in_strobe[k] with slot k full and not being drained in the same cycle SHALL:
- discard the new sample;
- keep the old sample;
- set overflow[k].
REQ-006 Drain and strobe in the same cycle on slot k SHALL load the new sample and leave the full flag set, with no overflow.
REQ-007 Strobes on a channel absent from the active mask SHALL be ignored, and that slot's full flag SHALL be cleared.
REQ-008 The state machine SHALL have two states, IDLE and SEND.
REQ-009 In IDLE, the block SHALL latch enable_mask into active_mask every cycle.
- It moves to SEND when active_mask is nonzero and every active slot is full.
- enable_mask changes are ignored while in SEND.
REQ-010 SEND SHALL present active slots in ascending channel order, one sample per handshake (out_valid and out_ready both high).
REQ-011 out_last SHALL be high only with the highest-indexed active channel; its handshake returns the state to IDLE.
REQ-012 Each handshake SHALL clear the drained slot's full flag, subject to REQ-006.
REQ-013 Outputs SHALL be registered; out_valid, out_I, out_Q, out_chan and out_last SHALL be held stable while out_valid is high and out_ready is low.
REQ-014 Latency: the strobe completing a frame at cycle t SHALL give out_valid high at cycle t+2.
REQ-015 With out_ready held high, back-to-back samples SHALL leave one per cycle with no bubbles inside a frame.
- One idle cycle is allowed between frames.
REQ-016 An all-zero enable_mask SHALL keep the block in IDLE with out_valid low.
REQ-017 clr_overflow SHALL clear all overflow bits.
- If clr_overflow coincides with a new overflow event on channel k, overflow[k] SHALL end up set (set wins).
REQ-018 Samples SHALL pass through bit-exact, with no scaling, rounding or sign change.

Reset
REQ-019 Assertion of rst_n low SHALL immediately and asynchronously:
- force state IDLE;
- clear all full flags, active_mask and overflow;
- drive out_valid, out_last, out_chan, out_I and out_Q to zero.
REQ-020 Reset mid-frame SHALL discard the partial frame; after release, the first frame SHALL contain only samples strobed after release.

Structure
REQ-021 Package rx_pkg SHALL hold:
- MAX_NRX = 8;
- the DW default of 24;
- the state enum {IDLE, SEND}.
REQ-022 The per-channel slot logic SHALL be one sub-module, rx_slot (holding register, full flag, overflow bit), instantiated NRX times.
REQ-023 The block SHALL be synthesizable with NRX=1 (out_last high on every sample).

Verification
REQ-024 The bench SHALL cover the following directed scenarios, each with a scoreboard checking order and bit-exact data.
- NRX=4, mask=4'b1111, channels 0..3 strobed in cycles 10,11,12,13 with I=k*16+1, Q=-(k*16+1), out_ready=1 -> out_valid first at cycle 15; chan 0,1,2,3 in cycles 15..18 with matching data; out_last only on chan 3.
- mask=4'b0101, strobes on all channels -> frame contains chan 0 then chan 2 only; out_last on chan 2; channels 1 and 3 never appear.
- out_ready=0 for 20 cycles while channel 1 strobes twice -> overflow[1]=1; the first sample is delivered after out_ready rises, not the second; clr_overflow pulse -> overflow=0.
- mask changed from 4'b1111 to 4'b0001 mid-SEND -> current frame completes with 4 samples; the next frame contains chan 0 only.
- rst_n pulsed low while out_valid=1 at chan 2 -> out_valid=0 in the same cycle; no stale sample after release.
- mask=0 with strobes for 100 cycles -> out_valid never asserts; overflow stays 0.

Source files
------------

// File: rtl/rx_pkg.sv
// rx_pkg: shared constants and types for the RX frame arbiter.
//   MAX_NRX    - largest supported receiver count
//   DW_DEFAULT - default I/Q component width
//   state_t    - frame arbiter state encoding
package rx_pkg;

  localparam int MAX_NRX    = 8;
  localparam int DW_DEFAULT = 24;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/rx_slot.sv
// rx_slot: one receiver's holding register with full flag and sticky
// overflow bit.
//   clock, rst_n   - clock, asynchronous active-low reset
//   active         - channel belongs to the current frame mask
//   strobe         - sample valid from the receiver
//   in_i, in_q     - incoming sample
//   drain          - arbiter is consuming this slot this cycle
//   clr_overflow   - clear request for the overflow bit
//   full           - slot holds an unsent sample
//   slot_i, slot_q - held sample
//   overflow       - a sample was dropped since the last clear
module rx_slot
  import rx_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 active,
  input  logic                 strobe,
  input  logic signed [DW-1:0] in_i,
  input  logic signed [DW-1:0] in_q,
  input  logic                 drain,
  input  logic                 clr_overflow,
  output logic                 full,
  output logic signed [DW-1:0] slot_i,
  output logic signed [DW-1:0] slot_q,
  output logic                 overflow
);

  logic load;
  logic drop;

  // A drain in the same cycle frees the slot, so the new sample is accepted.
  assign load = active && strobe && (!full || drain);
  assign drop = active && strobe && full && !drain;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (!active)     full <= 1'b0;
      else if (load)   full <= 1'b1;
      else if (drain)  full <= 1'b0;
      // A drop in the clearing cycle wins so no loss goes unreported.
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  // Sample storage is qualified by the full flag and needs no reset.
  always_ff @(posedge clock) begin
    if (load) begin
      slot_i <= in_i;
      slot_q <= in_q;
    end
  end

endmodule

// File: rtl/rx_frame_arbiter.sv
// rx_frame_arbiter: collects one sample per active receiver channel and
// emits them as a frame in ascending channel order over a valid/ready port.
//   clock, rst_n     - clock, asynchronous active-low reset
//   enable_mask      - channels taking part in the next frame
//   in_strobe        - per-channel one-cycle sample valid
//   in_I, in_Q       - packed samples, channel k at [k*DW +: DW]
//   out_valid/ready  - output handshake
//   out_I, out_Q     - sample, bit-exact copy of the input
//   out_chan         - source channel of the sample
//   out_last         - sample from the highest active channel
//   overflow         - sticky per-channel drop flags
//   clr_overflow     - clears all overflow flags
module rx_frame_arbiter
  import rx_pkg::*;
#(
  parameter int NRX = 4,
  parameter int DW  = DW_DEFAULT
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic [NRX-1:0]       enable_mask,
  input  logic [NRX-1:0]       in_strobe,
  input  logic [NRX*DW-1:0]    in_I,
  input  logic [NRX*DW-1:0]    in_Q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_I,
  output logic signed [DW-1:0] out_Q,
  output logic [2:0]           out_chan,
  output logic                 out_last,
  output logic [NRX-1:0]       overflow,
  input  logic                 clr_overflow
);

  state_t                state;
  logic [NRX-1:0]        active_mask;
  logic [NRX-1:0]        full;
  logic [NRX-1:0]        drain;
  logic signed [DW-1:0]  slot_i [NRX];
  logic signed [DW-1:0]  slot_q [NRX];

  logic                  handshake;
  logic                  all_full;
  logic                  has_next;
  logic [2:0]            first_chan;
  logic [2:0]            last_chan;
  logic [2:0]            next_chan;
  logic [2:0]            load_chan;
  logic signed [DW-1:0]  load_i;
  logic signed [DW-1:0]  load_q;

  for (genvar k = 0; k < NRX; k++) begin : g_slot
    rx_slot #(.DW(DW)) u_slot (
      .clock        (clock),
      .rst_n        (rst_n),
      .active       (active_mask[k]),
      .strobe       (in_strobe[k]),
      .in_i         (in_I[k*DW +: DW]),
      .in_q         (in_Q[k*DW +: DW]),
      .drain        (drain[k]),
      .clr_overflow (clr_overflow),
      .full         (full[k]),
      .slot_i       (slot_i[k]),
      .slot_q       (slot_q[k]),
      .overflow     (overflow[k])
    );
  end

  assign handshake = (state == SEND) && out_valid && out_ready;
  assign all_full  = (active_mask != '0) && ((full & active_mask) == active_mask);

  // Channel search over the frozen frame mask: lowest, highest and the
  // next active channel above the one currently presented.
  always_comb begin
    first_chan = '0;
    last_chan  = '0;
    next_chan  = '0;
    has_next   = 1'b0;
    for (int k = NRX - 1; k >= 0; k--) begin
      if (active_mask[k]) first_chan = 3'(k);
      if (active_mask[k] && (k > int'(out_chan))) begin
        next_chan = 3'(k);
        has_next  = 1'b1;
      end
    end
    for (int k = 0; k < NRX; k++) begin
      if (active_mask[k]) last_chan = 3'(k);
    end
  end

  assign load_chan = (state == IDLE) ? first_chan : next_chan;

  always_comb begin
    load_i = '0;
    load_q = '0;
    drain  = '0;
    for (int k = 0; k < NRX; k++) begin
      if (3'(k) == load_chan) begin
        load_i = slot_i[k];
        load_q = slot_q[k];
      end
      drain[k] = handshake && (3'(k) == out_chan);
    end
  end

  // Output stage: the next sample is loaded on the handshake edge, which
  // keeps a frame bubble-free and holds outputs steady while stalled.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      active_mask <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_chan    <= '0;
      out_I       <= '0;
      out_Q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (all_full) begin
            // Mask stays frozen on the launch edge so the frame matches it.
            state     <= SEND;
            out_valid <= 1'b1;
            out_chan  <= load_chan;
            out_I     <= load_i;
            out_Q     <= load_q;
            out_last  <= (load_chan == last_chan);
          end else begin
            active_mask <= enable_mask;
          end
        end
        SEND: begin
          if (handshake) begin
            if (has_next) begin
              out_chan <= load_chan;
              out_I    <= load_i;
              out_Q    <= load_q;
              out_last <= (load_chan == last_chan);
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
